// File: rtl/vxe_intr_coalesce_unit.sv
// vxe_intr_coalesce_unit
//   Interrupt control unit with coalescing. Rising edges on the CU interrupt
//   request lines are latched into raw-pending bits. A per-source mask selects
//   which pending bits are active. The host interrupt line is held back until
//   either enough sources are active or the active set has waited long enough.
//
// Ports
//   clk           clock
//   nrst          asynchronous active-low reset
//   i_cu_busy     CU busy; rising edges seen while high are dropped
//   i_cu_intr     CU interrupt request levels [NR_INT]
//   i_rio_mask    per-source enable, 1 = may raise o_intr [NR_INT]
//   o_rio_raw     raw pending bits, unmasked [NR_INT]
//   o_rio_active  raw & mask, combinational [NR_INT]
//   i_rio_ack_en  acknowledge strobe
//   i_rio_ack     bits to clear when i_rio_ack_en=1 [NR_INT]
//   i_rio_thresh  active-count threshold, 0 behaves as 1 [CNT_W]
//   i_rio_tmo     timeout in cycles, 0 disables the timeout [TMO_W]
//   o_rio_ovf     overflow bits, only with VXE_INTR_OVF_EN defined [NR_INT]
//   o_intr        registered level interrupt to the host
//
// Optional feature macro: VXE_INTR_OVF_EN (overflow tracking per source).

module vxe_intr_coalesce_unit #(
  parameter int NR_INT = 4,
  parameter int CNT_W  = 3,
  parameter int TMO_W  = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_cu_busy,
  input  logic [NR_INT-1:0] i_cu_intr,
  input  logic [NR_INT-1:0] i_rio_mask,
  output logic [NR_INT-1:0] o_rio_raw,
  output logic [NR_INT-1:0] o_rio_active,
  input  logic              i_rio_ack_en,
  input  logic [NR_INT-1:0] i_rio_ack,
  input  logic [CNT_W-1:0]  i_rio_thresh,
  input  logic [TMO_W-1:0]  i_rio_tmo,
`ifdef VXE_INTR_OVF_EN
  output logic [NR_INT-1:0] o_rio_ovf,
`endif
  output logic              o_intr
);

  localparam int POP_W = $clog2(NR_INT) + 1;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_ASSERTED = 1'b1;

  logic [NR_INT-1:0] raw_q, prev_q;
  logic [NR_INT-1:0] evt, clr, raw_d;
  logic [TMO_W-1:0]  timer_q, timer_d;
  logic [0:0]        state_q, state_d;
  logic [POP_W-1:0]  cnt;
  logic [CNT_W-1:0]  thr;
  logic              any_active, cnt_hit, tmo_hit, fire;

  // A held level never re-triggers because prev_q tracks the input every
  // cycle, even while busy; an edge masked by busy is therefore gone for good.
  assign evt   = i_cu_intr & ~prev_q & {NR_INT{~i_cu_busy}};
  assign clr   = i_rio_ack_en ? i_rio_ack : '0;
  // Event is ORed after the clear so a same-cycle event beats the ack.
  assign raw_d = evt | (raw_q & ~clr);

  assign o_rio_raw    = raw_q;
  assign o_rio_active = raw_q & i_rio_mask;
  assign any_active   = |o_rio_active;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < NR_INT; i++) begin
      cnt = cnt + POP_W'(o_rio_active[i]);
    end
  end

  assign thr     = (i_rio_thresh == '0) ? CNT_W'(1) : i_rio_thresh;
  assign cnt_hit = (32'(cnt) >= 32'(thr));
  assign tmo_hit = (i_rio_tmo != '0) && (timer_q >= (i_rio_tmo - TMO_W'(1)));
  assign fire    = any_active && (cnt_hit || tmo_hit);

  // Timer measures how long the active set has been waiting; it only runs
  // while something is active and the line is still held back.
  always_comb begin
    timer_d = timer_q;
    if (!any_active || o_intr) begin
      timer_d = '0;
    end else if (timer_q != '1) begin
      timer_d = timer_q + TMO_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (fire)        state_d = ST_ASSERTED;
      ST_ASSERTED: if (!any_active) state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  assign o_intr = (state_q == ST_ASSERTED);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      raw_q   <= '0;
      prev_q  <= '0;
      timer_q <= '0;
      state_q <= ST_IDLE;
    end else begin
      raw_q   <= raw_d;
      prev_q  <= i_cu_intr;
      timer_q <= timer_d;
      state_q <= state_d;
    end
  end

`ifdef VXE_INTR_OVF_EN
  // Overflow: a second event lands on a bit still pending and not being
  // acked this cycle. An ack of the bit clears it; set has priority.
  logic [NR_INT-1:0] ovf_q, ovf_set;

  assign ovf_set   = evt & raw_q & ~clr;
  assign o_rio_ovf = ovf_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_set | (ovf_q & ~clr);
    end
  end
`endif

endmodule

// File: tb/tb_vxe_intr_coalesce_unit.sv
// Testbench for vxe_intr_coalesce_unit (NR_INT=4, CNT_W=3, TMO_W=16).
// Expected values come from per-scenario tables and loops; they are queued
// when the stimulus is driven and popped when the DUT output is sampled.

module tb_vxe_intr_coalesce_unit;

  logic        clk = 1'b0;
  logic        nrst;
  logic        i_cu_busy;
  logic [3:0]  i_cu_intr;
  logic [3:0]  i_rio_mask;
  logic [3:0]  o_rio_raw;
  logic [3:0]  o_rio_active;
  logic        i_rio_ack_en;
  logic [3:0]  i_rio_ack;
  logic [2:0]  i_rio_thresh;
  logic [15:0] i_rio_tmo;
`ifdef VXE_INTR_OVF_EN
  logic [3:0]  o_rio_ovf;
`endif
  logic        o_intr;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [3:0] raw;
    logic [3:0] act;
    logic       intr;
  } exp_t;

  typedef struct packed {
    logic       busy;
    logic [3:0] intr;
    logic [3:0] mask;
    logic       ack_en;
    logic [3:0] ack;
    logic [2:0] thr;
    logic [3:0] e_raw;
    logic [3:0] e_act;
    logic       e_intr;
  } step_t;

  exp_t sb[$];

  vxe_intr_coalesce_unit #(.NR_INT(4), .CNT_W(3), .TMO_W(16)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .i_cu_busy    (i_cu_busy),
    .i_cu_intr    (i_cu_intr),
    .i_rio_mask   (i_rio_mask),
    .o_rio_raw    (o_rio_raw),
    .o_rio_active (o_rio_active),
    .i_rio_ack_en (i_rio_ack_en),
    .i_rio_ack    (i_rio_ack),
    .i_rio_thresh (i_rio_thresh),
    .i_rio_tmo    (i_rio_tmo),
`ifdef VXE_INTR_OVF_EN
    .o_rio_ovf    (o_rio_ovf),
`endif
    .o_intr       (o_intr)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input step_t s);
    i_cu_busy    = s.busy;
    i_cu_intr    = s.intr;
    i_rio_mask   = s.mask;
    i_rio_ack_en = s.ack_en;
    i_rio_ack    = s.ack;
    i_rio_thresh = s.thr;
  endtask

  task automatic idle_inputs();
    i_cu_busy    = 1'b0;
    i_cu_intr    = 4'b0000;
    i_rio_mask   = 4'b1111;
    i_rio_ack_en = 1'b0;
    i_rio_ack    = 4'b0000;
    i_rio_thresh = 3'd1;
    i_rio_tmo    = 16'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nrst = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    exp_t e;
    idle_inputs();
    nrst = 1'b0;
    sb.push_back('{raw: 4'b0000, act: 4'b0000, intr: 1'b0});
    #2;
    e = sb.pop_front();
    tests_run++;
    if ({o_rio_raw, o_rio_active, o_intr} !== {e.raw, e.act, e.intr}) begin
      tests_failed++;
      $display("FAIL reset: raw=%b act=%b intr=%b, expected raw=%b act=%b intr=%b",
               o_rio_raw, o_rio_active, o_intr, e.raw, e.act, e.intr);
    end
    tick();
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    exp_t  e;
    step_t tbl [4] = '{
      '{1'b0, 4'b1010, 4'b1111, 1'b0, 4'b0000, 3'd1, 4'b1010, 4'b1010, 1'b0},
      '{1'b0, 4'b0000, 4'b1111, 1'b0, 4'b0000, 3'd1, 4'b1010, 4'b1010, 1'b1},
      '{1'b0, 4'b0000, 4'b1111, 1'b1, 4'b1010, 3'd1, 4'b0000, 4'b0000, 1'b1},
      '{1'b0, 4'b0000, 4'b1111, 1'b0, 4'b0000, 3'd1, 4'b0000, 4'b0000, 1'b0}
    };
    do_reset();
    foreach (tbl[k]) begin
      drive(tbl[k]);
      sb.push_back('{raw: tbl[k].e_raw, act: tbl[k].e_act, intr: tbl[k].e_intr});
      tick();
      e = sb.pop_front();
      tests_run++;
      if ({o_rio_raw, o_rio_active, o_intr} !== {e.raw, e.act, e.intr}) begin
        tests_failed++;
        $display("FAIL basic step %0d: raw=%b act=%b intr=%b, expected raw=%b act=%b intr=%b",
                 k, o_rio_raw, o_rio_active, o_intr, e.raw, e.act, e.intr);
      end
    end
  endtask

  task automatic test_thresh();
    exp_t  e;
    step_t tbl [7] = '{
      '{1'b0, 4'b0010, 4'b1111, 1'b0, 4'b0000, 3'd3, 4'b0010, 4'b0010, 1'b0},
      '{1'b0, 4'b1010, 4'b1111, 1'b0, 4'b0000, 3'd3, 4'b1010, 4'b1010, 1'b0},
      '{1'b0, 4'b1010, 4'b1111, 1'b0, 4'b0000, 3'd3, 4'b1010, 4'b1010, 1'b0},
      '{1'b0, 4'b1011, 4'b1111, 1'b0, 4'b0000, 3'd3, 4'b1011, 4'b1011, 1'b0},
      '{1'b0, 4'b0000, 4'b1111, 1'b0, 4'b0000, 3'd3, 4'b1011, 4'b1011, 1'b1},
      '{1'b0, 4'b0000, 4'b1111, 1'b1, 4'b1011, 3'd3, 4'b0000, 4'b0000, 1'b1},
      '{1'b0, 4'b0000, 4'b1111, 1'b0, 4'b0000, 3'd3, 4'b0000, 4'b0000, 1'b0}
    };
    do_reset();
    foreach (tbl[k]) begin
      drive(tbl[k]);
      sb.push_back('{raw: tbl[k].e_raw, act: tbl[k].e_act, intr: tbl[k].e_intr});
      tick();
      e = sb.pop_front();
      tests_run++;
      if ({o_rio_raw, o_rio_active, o_intr} !== {e.raw, e.act, e.intr}) begin
        tests_failed++;
        $display("FAIL thresh step %0d: raw=%b act=%b intr=%b, expected raw=%b act=%b intr=%b",
                 k, o_rio_raw, o_rio_active, o_intr, e.raw, e.act, e.intr);
      end
    end
  endtask

  // thr=4 with one source never reaches the count; only the 10-cycle timeout
  // fires. The second round checks that the timer starts over from zero.
  task automatic test_timeout();
    exp_t e;
    do_reset();
    i_rio_thresh = 3'd4;
    i_rio_tmo    = 16'd10;
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k <= 12; k++) begin
        i_cu_intr    = (k == 0) ? 4'b0100 : 4'b0000;
        i_rio_ack_en = (k == 11);
        i_rio_ack    = (k == 11) ? 4'b0100 : 4'b0000;
        if (k <= 10)
          sb.push_back('{raw: 4'b0100, act: 4'b0100, intr: (k == 10)});
        else
          sb.push_back('{raw: 4'b0000, act: 4'b0000, intr: (k == 11)});
        tick();
        e = sb.pop_front();
        tests_run++;
        if ({o_rio_raw, o_rio_active, o_intr} !== {e.raw, e.act, e.intr}) begin
          tests_failed++;
          $display("FAIL timeout rep %0d cycle %0d: raw=%b act=%b intr=%b, expected raw=%b act=%b intr=%b",
                   rep, k, o_rio_raw, o_rio_active, o_intr, e.raw, e.act, e.intr);
        end
      end
    end
  endtask

  task automatic test_busy_ack();
    exp_t  e;
    step_t tbl [5] = '{
      '{1'b1, 4'b0001, 4'b1111, 1'b0, 4'b0000, 3'd4, 4'b0000, 4'b0000, 1'b0},
      '{1'b0, 4'b0001, 4'b1111, 1'b0, 4'b0000, 3'd4, 4'b0000, 4'b0000, 1'b0},
      '{1'b0, 4'b1001, 4'b1111, 1'b1, 4'b1000, 3'd4, 4'b1000, 4'b1000, 1'b0},
      '{1'b0, 4'b1001, 4'b1111, 1'b1, 4'b0001, 3'd4, 4'b1000, 4'b1000, 1'b0},
      '{1'b0, 4'b1001, 4'b1111, 1'b1, 4'b1000, 3'd4, 4'b0000, 4'b0000, 1'b0}
    };
    do_reset();
    foreach (tbl[k]) begin
      drive(tbl[k]);
      sb.push_back('{raw: tbl[k].e_raw, act: tbl[k].e_act, intr: tbl[k].e_intr});
      tick();
      e = sb.pop_front();
      tests_run++;
      if ({o_rio_raw, o_rio_active, o_intr} !== {e.raw, e.act, e.intr}) begin
        tests_failed++;
        $display("FAIL busy_ack step %0d: raw=%b act=%b intr=%b, expected raw=%b act=%b intr=%b",
                 k, o_rio_raw, o_rio_active, o_intr, e.raw, e.act, e.intr);
      end
    end
  endtask

  // Mask changes and a threshold raise while asserted, then a mid-run reset.
  task automatic test_mask_reset();
    exp_t  e;
    step_t tbl [6] = '{
      '{1'b0, 4'b1010, 4'b1111, 1'b0, 4'b0000, 3'd1, 4'b1010, 4'b1010, 1'b0},
      '{1'b0, 4'b0000, 4'b1111, 1'b0, 4'b0000, 3'd1, 4'b1010, 4'b1010, 1'b1},
      '{1'b0, 4'b0000, 4'b1000, 1'b0, 4'b0000, 3'd1, 4'b1010, 4'b1000, 1'b1},
      '{1'b0, 4'b0000, 4'b1000, 1'b0, 4'b0000, 3'd7, 4'b1010, 4'b1000, 1'b1},
      '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3'd1, 4'b1010, 4'b0000, 1'b0},
      '{1'b0, 4'b0000, 4'b1111, 1'b0, 4'b0000, 3'd1, 4'b1010, 4'b1010, 1'b1}
    };
    do_reset();
    foreach (tbl[k]) begin
      drive(tbl[k]);
      sb.push_back('{raw: tbl[k].e_raw, act: tbl[k].e_act, intr: tbl[k].e_intr});
      tick();
      e = sb.pop_front();
      tests_run++;
      if ({o_rio_raw, o_rio_active, o_intr} !== {e.raw, e.act, e.intr}) begin
        tests_failed++;
        $display("FAIL mask step %0d: raw=%b act=%b intr=%b, expected raw=%b act=%b intr=%b",
                 k, o_rio_raw, o_rio_active, o_intr, e.raw, e.act, e.intr);
      end
    end
    // Asynchronous reset mid-operation, sampled before any clock edge.
    nrst = 1'b0;
    sb.push_back('{raw: 4'b0000, act: 4'b0000, intr: 1'b0});
    #2;
    e = sb.pop_front();
    tests_run++;
    if ({o_rio_raw, o_rio_active, o_intr} !== {e.raw, e.act, e.intr}) begin
      tests_failed++;
      $display("FAIL mid_reset: raw=%b act=%b intr=%b, expected all zero",
               o_rio_raw, o_rio_active, o_intr);
    end
    tick();
    nrst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{raw: 4'b0000, act: 4'b0000, intr: 1'b0});
      tick();
      e = sb.pop_front();
      tests_run++;
      if ({o_rio_raw, o_rio_active, o_intr} !== {e.raw, e.act, e.intr}) begin
        tests_failed++;
        $display("FAIL post_reset cycle %0d: raw=%b act=%b intr=%b, expected all zero",
                 k, o_rio_raw, o_rio_active, o_intr);
      end
    end
  endtask

  // Partial acks with thresh=0, which behaves as a threshold of 1.
  task automatic test_partial_ack();
    exp_t  e;
    step_t tbl [6] = '{
      '{1'b0, 4'b0110, 4'b1111, 1'b0, 4'b0000, 3'd0, 4'b0110, 4'b0110, 1'b0},
      '{1'b0, 4'b0000, 4'b1111, 1'b0, 4'b0000, 3'd0, 4'b0110, 4'b0110, 1'b1},
      '{1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0100, 3'd0, 4'b0010, 4'b0010, 1'b1},
      '{1'b0, 4'b0000, 4'b1111, 1'b0, 4'b0000, 3'd0, 4'b0010, 4'b0010, 1'b1},
      '{1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0010, 3'd0, 4'b0000, 4'b0000, 1'b1},
      '{1'b0, 4'b0000, 4'b1111, 1'b0, 4'b0000, 3'd0, 4'b0000, 4'b0000, 1'b0}
    };
    do_reset();
    foreach (tbl[k]) begin
      drive(tbl[k]);
      sb.push_back('{raw: tbl[k].e_raw, act: tbl[k].e_act, intr: tbl[k].e_intr});
      tick();
      e = sb.pop_front();
      tests_run++;
      if ({o_rio_raw, o_rio_active, o_intr} !== {e.raw, e.act, e.intr}) begin
        tests_failed++;
        $display("FAIL partial step %0d: raw=%b act=%b intr=%b, expected raw=%b act=%b intr=%b",
                 k, o_rio_raw, o_rio_active, o_intr, e.raw, e.act, e.intr);
      end
    end
  endtask

  // thr=7 exceeds NR_INT and tmo=0: raw latches but the line never asserts.
  task automatic test_never_fire();
    exp_t e;
    do_reset();
    i_rio_thresh = 3'd7;
    i_rio_tmo    = 16'd0;
    for (int k = 0; k < 20; k++) begin
      i_cu_intr = (k == 0) ? 4'b1111 : 4'b0000;
      sb.push_back('{raw: 4'b1111, act: 4'b1111, intr: 1'b0});
      tick();
      e = sb.pop_front();
      tests_run++;
      if ({o_rio_raw, o_rio_active, o_intr} !== {e.raw, e.act, e.intr}) begin
        tests_failed++;
        $display("FAIL never_fire cycle %0d: raw=%b act=%b intr=%b, expected raw=%b act=%b intr=%b",
                 k, o_rio_raw, o_rio_active, o_intr, e.raw, e.act, e.intr);
      end
    end
  endtask

`ifdef VXE_INTR_OVF_EN
  task automatic test_ovf();
    logic [3:0] ovf_q[$];
    logic [3:0] e_ovf;
    exp_t       e;
    logic [3:0] t_intr  [7] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010};
    logic       t_ack   [7] = '{1'b0,    1'b0,    1'b0,    1'b1,    1'b0,    1'b0,    1'b1};
    logic [3:0] t_raw   [7] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0010};
    logic [3:0] t_ovf   [7] = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    do_reset();
    i_rio_thresh = 3'd7;
    foreach (t_intr[k]) begin
      i_cu_intr    = t_intr[k];
      i_rio_ack_en = t_ack[k];
      i_rio_ack    = t_ack[k] ? 4'b0010 : 4'b0000;
      sb.push_back('{raw: t_raw[k], act: t_raw[k], intr: 1'b0});
      ovf_q.push_back(t_ovf[k]);
      tick();
      e     = sb.pop_front();
      e_ovf = ovf_q.pop_front();
      tests_run++;
      if ({o_rio_raw, o_rio_ovf, o_intr} !== {e.raw, e_ovf, e.intr}) begin
        tests_failed++;
        $display("FAIL ovf step %0d: raw=%b ovf=%b intr=%b, expected raw=%b ovf=%b intr=%b",
                 k, o_rio_raw, o_rio_ovf, o_intr, e.raw, e_ovf, e.intr);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_thresh();
    test_timeout();
    test_busy_ack();
    test_mask_reset();
    test_partial_ack();
    test_never_fire();
`ifdef VXE_INTR_OVF_EN
    test_ovf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vxe_intr_coalesce_unit.md
Name: vxe_intr_coalesce_unit

Overview:
Next-generation VxE interrupt control unit. It collects NR_INT event sources from the control unit (CU) and latches them on their rising edges into raw-pending bits. It applies a per-source enable mask and drives a single interrupt line to the host. Interrupt coalescing holds back the line until either a programmable count of active sources is reached or a programmable timeout expires. The block sits between the CU and the RegIO register file, and replaces the plain mask/ack unit.

Parameters:
NR_INT, 4, number of interrupt sources (1..32)
CNT_W, 3, width of the threshold field; must hold NR_INT
TMO_W, 16, width of the timeout field and of the internal timer

Ports:
clk  in  1  clock
nrst  in  1  reset; asynchronous, active-low
i_cu_busy  in  1  CU busy; new events are not captured while high
i_cu_intr  in  NR_INT  CU interrupt request levels
i_rio_mask  in  NR_INT  per-source enable; 1 = source may raise o_intr
o_rio_raw  out  NR_INT  raw pending bits, unmasked
o_rio_active  out  NR_INT  raw & mask
i_rio_ack_en  in  1  acknowledge strobe, one cycle
i_rio_ack  in  NR_INT  bits to clear when i_rio_ack_en=1
i_rio_thresh  in  CNT_W  coalescing count threshold; 0 is treated as 1
i_rio_tmo  in  TMO_W  coalescing timeout in cycles; 0 disables the timeout
o_intr  out  1  registered interrupt line to the host

Behaviour:
- Reset (nrst=0, asynchronous): raw, prev_intr, timer and o_intr are all cleared to 0. o_rio_raw, o_rio_active and o_intr read 0. Asserting reset mid-operation discards all pending state; nothing is re-raised after release unless a new rising edge arrives.
- Edge detect: prev_intr <= i_cu_intr every cycle, regardless of busy. An event on source i is i_cu_intr[i] & ~prev_intr[i] & ~i_cu_busy.
  - A rising edge that occurs while busy=1 is lost. It is not deferred.
  - A level that is held high never re-triggers.
- Raw update, per bit, registered:
  - raw_next = event | (raw & ~(ack_en ? ack : 0)).
  - An event and an ack on the same bit in the same cycle: the event wins and the bit stays 1.
  - Ack of a bit that is 0 has no effect.
  - Latency: event to o_rio_raw is 1 cycle.
- o_rio_active = raw & i_rio_mask, combinational from registered raw. A mask change is reflected in the same cycle.
- cnt = popcount(o_rio_active), width log2(NR_INT)+1. thr = (i_rio_thresh==0) ? 1 : i_rio_thresh.
- Timer (TMO_W bits):
  - Cleared when active==0 or o_intr==1.
  - Otherwise increments by 1 per cycle, saturating at all-ones, with no wrap.
- fire = (active!=0) & ((cnt >= thr) | (i_rio_tmo!=0 & timer >= i_rio_tmo-1)).
- o_intr state machine, registered:
  - IDLE (o_intr=0): go to ASSERTED when fire=1. o_intr is 1 in the cycle after fire.
  - ASSERTED (o_intr=1): stay while active!=0. Return to IDLE when active==0, so o_intr drops in the cycle after the last active bit clears (ack or mask).
  - The line is level-type. New events arriving while ASSERTED keep it high.
- Boundaries:
  - thr > NR_INT: only the timeout can fire. If i_rio_tmo=0 as well, o_intr never asserts; raw still latches.
  - Raising thr or clearing the mask while ASSERTED does not drop o_intr unless active becomes 0.
  - Partial ack leaves o_intr high while any active bit remains.

Optional Feature:
VXE_INTR_OVF_EN
- Compiled in: adds output o_rio_ovf [NR_INT], reset to 0.
  - ovf[i] sets, registered, when an event on i occurs while raw[i] is already 1, and that same cycle's ack does not clear raw[i].
  - ovf[i] clears on an ack of bit i. If a set and a clear hit ovf[i] in the same cycle, the set wins.
  - ovf does not affect o_intr.
- Compiled out: the port and its logic are absent. Overlapping events merge silently into raw.

Test Plan:
- thr=1, tmo=0, mask=4'b1111; pulse i_cu_intr=4'b1010 with busy=0 -> raw=4'b1010 after 1 cycle; o_intr=1 the following cycle.
- thr=3, tmo=0, mask=4'b1111; events on bits 1 and 3 -> o_intr stays 0; a third event on bit 0 -> o_intr=1 one cycle after raw=4'b1011.
- thr=4, tmo=10, single event on bit 2 -> o_intr rises 10 cycles after raw[2] sets; ack 4'b0100 -> o_intr=0 the next cycle; timer restarts from 0 on the next event.
- busy=1 during the rising edge of bit 0, busy=0 afterward with the level held -> raw stays 0. Event on bit 3 with ack_en=1, ack=4'b1000 in the same cycle -> raw[3]=1.
- o_intr=1 with active=4'b1010; mask to 4'b1000 -> o_intr stays 1; mask to 4'b0000 -> o_intr=0 next cycle, raw still 4'b1010. Assert nrst mid-sequence -> all outputs 0 immediately.
- VXE_INTR_OVF_EN: two events on bit 1 without an ack in between -> o_rio_ovf=4'b0010; ack 4'b0010 -> raw[1]=0 and ovf[1]=0.
